// File: rtl/lza_norm_pipe.sv
// Two-stage leading-one encoder and normalizing shifter with one-bit LZA correction and exponent adjust.
// Latency 2 cycles; valid/ready on both sides, holds up to 2 beats under backpressure, in_ready combinational.
module lza_norm_pipe #(
    parameter int MW = 27,
    parameter int EW = 8,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] lza_e,
    input  logic [MW-1:0] sum_in,
    input  logic [EW-1:0] exp_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] mant_out,
    output logic [EW-1:0] exp_out,
    output logic [CW-1:0] lz_out,
    output logic          zero_out,
    output logic          uflow_out
);

    logic          en1, en2;
    logic          v1_q, v1_d, v2_q, v2_d;
    logic [CW-1:0] lzp_q, lzp_d;
    logic [MW-1:0] sum1_q, sum1_d;
    logic [EW-1:0] exp1_q, exp1_d;
    logic          zero1_q, zero1_d;
    logic [MW-1:0] mant_q, mant_d;
    logic [EW-1:0] exp2_q, exp2_d;
    logic [CW-1:0] lz_q, lz_d;
    logic          zero2_q, zero2_d;
    logic          uflow_q, uflow_d;

    logic [CW-1:0] lz_enc;
    logic [MW-1:0] sh;
    logic [CW:0]   lz_inc;
    logic [CW-1:0] lz_fix;
    logic [EW:0]   ediff;

    assign en2      = !v2_q || out_ready;
    assign en1      = !v1_q || en2;
    assign in_ready = en1;

    // Bit 0 is excluded from the scan, so an indicator without it still lands on MW-1.
    always_comb begin
        lz_enc = CW'(MW - 1);
        for (int i = 1; i < MW; i++) begin
            if (lza_e[i]) lz_enc = CW'(MW - 1 - i);
        end
    end

    always_comb begin
        v1_d    = en1 ? in_valid : v1_q;
        lzp_d   = lzp_q;
        sum1_d  = sum1_q;
        exp1_d  = exp1_q;
        zero1_d = zero1_q;
        if (en1 && in_valid) begin
            lzp_d   = lz_enc;
            sum1_d  = sum_in;
            exp1_d  = exp_in;
            zero1_d = (sum_in == '0);
        end
    end

    always_comb begin
        sh     = sum1_q << lzp_q;
        lz_inc = {1'b0, lzp_q} + (CW+1)'(1);
        lz_fix = lzp_q;
        if (zero1_q) begin
            lz_fix = '0;
        end else if (!sh[MW-1]) begin
            lz_fix = (lz_inc > (CW+1)'(MW - 1)) ? CW'(MW - 1) : lz_inc[CW-1:0];
        end
        ediff = {1'b0, exp1_q} - {{(EW+1-CW){1'b0}}, lz_fix};
    end

    always_comb begin
        v2_d    = en2 ? v1_q : v2_q;
        mant_d  = mant_q;
        exp2_d  = exp2_q;
        lz_d    = lz_q;
        zero2_d = zero2_q;
        uflow_d = uflow_q;
        if (en2 && v1_q) begin
            lz_d    = lz_fix;
            zero2_d = zero1_q;
            if (zero1_q) begin
                mant_d  = '0;
                exp2_d  = '0;
                uflow_d = 1'b0;
            end else begin
                mant_d  = sh[MW-1] ? sh : (sh << 1);
                uflow_d = ediff[EW];
                exp2_d  = ediff[EW] ? '0 : ediff[EW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            lzp_q   <= '0;
            sum1_q  <= '0;
            exp1_q  <= '0;
            zero1_q <= 1'b0;
            mant_q  <= '0;
            exp2_q  <= '0;
            lz_q    <= '0;
            zero2_q <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            lzp_q   <= lzp_d;
            sum1_q  <= sum1_d;
            exp1_q  <= exp1_d;
            zero1_q <= zero1_d;
            mant_q  <= mant_d;
            exp2_q  <= exp2_d;
            lz_q    <= lz_d;
            zero2_q <= zero2_d;
            uflow_q <= uflow_d;
        end
    end

    assign out_valid = v2_q;
    assign mant_out  = mant_q;
    assign exp_out   = exp2_q;
    assign lz_out    = lz_q;
    assign zero_out  = zero2_q;
    assign uflow_out = uflow_q;

endmodule

// File: tb/tb_lza_norm_pipe.sv
// Scoreboard bench for lza_norm_pipe: directed spec vectors, stall, throughput and mid-stream reset.
module tb_lza_norm_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] lza_e;
    logic [26:0] sum_in;
    logic [7:0]  exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] mant_out;
    logic [7:0]  exp_out;
    logic [4:0]  lz_out;
    logic        zero_out;
    logic        uflow_out;
    logic [41:0] out_dat;

    lza_norm_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lza_e     (lza_e),
        .sum_in    (sum_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .lz_out    (lz_out),
        .zero_out  (zero_out),
        .uflow_out (uflow_out)
    );

    always #5 clk = ~clk;

    assign out_dat = {mant_out, exp_out, lz_out, zero_out, uflow_out};

    typedef struct {
        logic [26:0] mant;
        logic [7:0]  ex;
        logic [4:0]  lz;
        logic        zero;
        logic        uflow;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur_exp;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_out = 0;
    bit          chk_lat = 1'b0;
    bit          hold_prev = 1'b0;
    logic [41:0] prev_dat;

    function automatic exp_t mk(input logic [26:0] m, input logic [7:0] e, input logic [4:0] l,
                                input logic z, input logic u);
        exp_t r;
        r.mant = m; r.ex = e; r.lz = l; r.zero = z; r.uflow = u; r.acc = 0;
        return r;
    endfunction

    // Reference: leading-one search from the top, shift, then one-bit fix-up.
    function automatic exp_t model(input logic [26:0] l, input logic [26:0] s, input logic [7:0] e);
        exp_t        r;
        int          p = 26;
        int          k;
        bit          f = 1'b0;
        logic [26:0] m;
        for (int i = 26; i >= 1; i--) begin
            if (!f && l[i]) begin p = 26 - i; f = 1'b1; end
        end
        r.acc = 0;
        if (s == 27'd0) begin
            r.mant = '0; r.ex = '0; r.lz = '0; r.zero = 1'b1; r.uflow = 1'b0;
        end else begin
            m = s << p;
            k = p;
            if (!m[26]) begin m = m << 1; k = p + 1; end
            if (k > 26) k = 26;
            r.mant = m; r.lz = 5'(k); r.zero = 1'b0;
            if (k > int'(e)) begin r.uflow = 1'b1; r.ex = '0; end
            else begin r.uflow = 1'b0; r.ex = 8'(int'(e) - k); end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        cyc++;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_dat !== prev_dat) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%b dat=%h, want v=1 dat=%h", out_valid, out_dat, prev_dat);
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got dat=%h, want no beat", out_dat);
                end else begin
                    x = sb.pop_front();
                    if (out_dat !== {x.mant, x.ex, x.lz, x.zero, x.uflow}) begin
                        n_fail++;
                        $display("FAIL beat_data: got mant=%h exp=%0d lz=%0d z=%b u=%b, want mant=%h exp=%0d lz=%0d z=%b u=%b",
                                 mant_out, exp_out, lz_out, zero_out, uflow_out, x.mant, x.ex, x.lz, x.zero, x.uflow);
                    end
                    if (chk_lat) begin
                        n_chk++;
                        if (cyc - x.acc !== 2) begin
                            n_fail++;
                            $display("FAIL latency: got %0d, want 2", cyc - x.acc);
                        end
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_dat  = out_dat;
            if (in_valid && in_ready) begin
                x = cur_exp;
                x.acc = cyc;
                sb.push_back(x);
            end
        end
    end

    task automatic send(input logic [26:0] l, input logic [26:0] s, input logic [7:0] e, input exp_t x);
        int t = 0;
        lza_e = l; sum_in = s; exp_in = e; cur_exp = x; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want 1", t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin @(negedge clk); t++; end
        n_chk++;
        if (sb.size() != 0 || out_valid) begin
            n_fail++;
            $display("FAIL drain: got %0d beats pending, want 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        lza_e = '0; sum_in = '0; exp_in = '0; cur_exp = mk('0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_dat !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b dat=%h, want v=0 dat=0", out_valid, out_dat);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        out_ready = 1'b1; chk_lat = 1'b1;
        send(27'h0400000, 27'h0400000, 8'd100, mk(27'h4000000, 8'd96, 5'd4, 1'b0, 1'b0));
        drain();
        send(27'h0400001, 27'h0200000, 8'd100, mk(27'h4000000, 8'd95, 5'd5, 1'b0, 1'b0));
        drain();
        send(27'h0000001, 27'h0000000, 8'd50, mk(27'h0, 8'd0, 5'd0, 1'b1, 1'b0));
        drain();
        send(27'h0000010, 27'h0000010, 8'd3, mk(27'h4000000, 8'd0, 5'd22, 1'b0, 1'b1));
        drain();
        send(27'h0000001, 27'h0000001, 8'd26, mk(27'h4000000, 8'd0, 5'd26, 1'b0, 1'b0));
        drain();
        send(27'h0000001, 27'h0000002, 8'd100, mk(27'h0000000, 8'd74, 5'd26, 1'b0, 1'b0));
        drain();
        chk_lat = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n0 = n_out;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    if (k == 2) begin
                        n_chk++;
                        if (in_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL stall_in_ready: got %b, want 0", in_ready);
                        end
                    end
                    send(27'h0400001, 27'h0400000 + 27'(k), 8'(100 + k),
                         model(27'h0400001, 27'h0400000 + 27'(k), 8'(100 + k)));
                end
            end
            begin
                int t = 0;
                while (!out_valid && t < 20) begin @(negedge clk); t++; end
                repeat (3) @(negedge clk);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        n_chk++;
        if (n_out - n0 !== 4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d beats, want 4", n_out - n0);
        end
    endtask

    task automatic test_throughput();
        int          n0 = n_out;
        int          p, q;
        logic [26:0] s, l, one;
        logic [7:0]  e;
        out_ready = 1'b1; chk_lat = 1'b1; one = 27'd1;
        for (int k = 0; k < 100; k++) begin
            p = int'($urandom_range(0, 26));
            if ($urandom_range(0, 15) == 0) s = '0;
            else s = (one << p) | (27'($urandom) & ((one << p) - one));
            q = (p < 26 && $urandom_range(0, 1) == 1) ? p + 1 : p;
            l = (one << q) | (27'($urandom) & ((one << q) - one)) | one;
            e = 8'($urandom);
            n_chk++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL thru_in_ready: got %b, want 1 at beat %0d", in_ready, k);
            end
            send(l, s, e, model(l, s, e));
        end
        drain();
        n_chk++;
        if (n_out - n0 !== 100) begin
            n_fail++;
            $display("FAIL thru_count: got %0d beats, want 100", n_out - n0);
        end
        chk_lat = 1'b0;
    endtask

    task automatic test_midstream_reset();
        out_ready = 1'b0;
        send(27'h0400001, 27'h0400000, 8'd10, model(27'h0400001, 27'h0400000, 8'd10));
        send(27'h0400001, 27'h0200000, 8'd10, model(27'h0400001, 27'h0200000, 8'd10));
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_dat !== 42'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b dat=%h, want v=0 dat=0", out_valid, out_dat);
        end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_in_ready: got %b, want 1", in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_beat: got out_valid=%b, want 0 at cycle %0d", out_valid, k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_throughput();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
